word24_byte_serializer: RTL

- Downstream consumer of proj1's 24-bit output stream: captures each word strobed by ena_in into a small FIFO.
- Emits each word as three bytes, MSB first, on a valid/ready byte interface for the narrow output/link stage.
- Absorbs bursts of ena strobes and flags data loss on overflow.

---
 rtl/word24_byte_serializer_if.sv | 25 ++
 rtl/word24_byte_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/word24_byte_serializer_if.sv
// Word-in / byte-out bus of the 24-bit word to byte serializer.
// The master modport drives words in and accepts bytes; the slave modport is the serializer itself.
interface word24_byte_serializer_if #(
  parameter int unsigned AW = 3
);
  logic [23:0] in;
  logic        ena_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        last_byte;
  logic [AW:0] level;
  logic        full;
  logic        overflow;

  modport master (
    output in, ena_in, byte_ready,
    input  byte_out, byte_valid, last_byte, level, full, overflow
  );

  modport slave (
    input  in, ena_in, byte_ready,
    output byte_out, byte_valid, last_byte, level, full, overflow
  );
endinterface

// File: rtl/word24_byte_serializer.sv
// Buffers strobed 24-bit words in a FIFO and emits each as three bytes, MSB first,
// on a valid/ready byte port. Words arriving while the FIFO is full are dropped and flagged.
module word24_byte_serializer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic                    clk,
  input logic                    clr_n,
  word24_byte_serializer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StB2, StB1, StB0} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  // Only the two bytes still to be sent are kept; the top byte goes straight to byte_out.
  logic [15:0]   sr_q, sr_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          last_byte_q, last_byte_d;

  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   head;
  logic          wr_en, pop, xfer, have_word;

  assign wr_en     = bus.ena_in & ~full_q;
  assign xfer      = byte_valid_q & bus.byte_ready;
  assign have_word = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in;
    end
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    last_byte_d  = last_byte_q;
    pop          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (have_word) begin
          pop          = 1'b1;
          sr_d         = head[15:0];
          byte_out_d   = head[23:16];
          byte_valid_d = 1'b1;
          last_byte_d  = 1'b0;
          state_d      = StB2;
        end
      end
      StB2: begin
        if (xfer) begin
          byte_out_d = sr_q[15:8];
          state_d    = StB1;
        end
      end
      StB1: begin
        if (xfer) begin
          byte_out_d  = sr_q[7:0];
          last_byte_d = 1'b1;
          state_d     = StB0;
        end
      end
      StB0: begin
        if (xfer) begin
          // Reload on the same edge so consecutive words stream without a bubble.
          if (have_word) begin
            pop          = 1'b1;
            sr_d         = head[15:0];
            byte_out_d   = head[23:16];
            byte_valid_d = 1'b1;
            last_byte_d  = 1'b0;
            state_d      = StB2;
          end else begin
            byte_out_d   = 8'h00;
            byte_valid_d = 1'b0;
            last_byte_d  = 1'b0;
            state_d      = StIdle;
          end
        end
      end
      default: begin
        state_d      = StIdle;
        byte_valid_d = 1'b0;
        last_byte_d  = 1'b0;
        byte_out_d   = 8'h00;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!wr_en && pop) begin
      level_d = level_q - 1'b1;
    end
    full_d     = (level_d == (AW + 1)'(DEPTH));
    overflow_d = overflow_q | (bus.ena_in & full_q);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      sr_q         <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      last_byte_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      sr_q         <= sr_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      last_byte_q  <= last_byte_d;
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.last_byte  = last_byte_q;
  assign bus.level      = level_q;
  assign bus.full       = full_q;
  assign bus.overflow   = overflow_q;

endmodule
